// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types for the matrix-vector multiplier result drain
package mvm_pkg;

    localparam int MVM_B     = 20;
    localparam int MVM_OUT_W = 32;

    typedef logic signed [2*MVM_B-1:0]  acc_t;
    typedef logic signed [MVM_OUT_W-1:0] out_t;

    typedef struct packed {
        logic sat;
        logic last;
        out_t data;
    } drain_word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE
    } drain_state_t;

endpackage

// File: rtl/mvm_drain_fifo.sv
// rtl/mvm_drain_fifo.sv - synchronous show-ahead FIFO with occupancy count
module mvm_drain_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic             full;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mvm_result_drain.sv
// rtl/mvm_result_drain.sv - captures a K-word result burst, saturates it and streams it out
module mvm_result_drain
    import mvm_pkg::*;
#(
    parameter int K      = 8,
    parameter int B      = 20,
    parameter int OUT_W  = 32,
    parameter int FRAC   = 0,
    parameter int OFFSET = 1,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    done_in,
    input  logic signed [2*B-1:0]   y_in,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_last,
    output logic                    m_sat,
    output logic                    busy,
    output logic                    drop
);

    localparam int AW = 2*B;
    localparam int CW = (OFFSET > 1) ? $clog2(OFFSET) : 1;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int NW = $clog2(DEPTH) + 1;
    localparam int EW = OUT_W + 2;

    drain_state_t   state;
    drain_state_t   state_next;
    logic [CW-1:0]  wait_cnt;
    logic [CW-1:0]  wait_cnt_next;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_next;
    logic           drop_next;
    logic           push;
    logic           fits;
    logic [NW-1:0]  count;
    logic           empty;
    logic [EW-1:0]  head;
    logic [EW-1:0]  entry;

    logic signed [AW-1:0] t;
    logic [OUT_W-1:0]     word_data;
    logic                 word_sat;

    assign t = y_in >>> FRAC;

    generate
        if (OUT_W >= AW) begin : g_wide
            assign word_data = OUT_W'(t);
            assign word_sat  = 1'b0;
        end else if (OUT_W >= AW - FRAC) begin : g_trunc
            // The shift already left only sign copies above OUT_W.
            assign word_data = t[OUT_W-1:0];
            assign word_sat  = 1'b0;
        end else begin : g_sat
            localparam int UW = AW - OUT_W + 1;
            logic [UW-1:0] upper;
            logic          ovf_pos;
            logic          ovf_neg;
            assign upper     = t[AW-1:OUT_W-1];
            assign ovf_pos   = !upper[UW-1] && (|upper);
            assign ovf_neg   = upper[UW-1] && !(&upper);
            assign word_data = ovf_pos ? {1'b0, {(OUT_W-1){1'b1}}} :
                               ovf_neg ? {1'b1, {(OUT_W-1){1'b0}}} :
                                         t[OUT_W-1:0];
            assign word_sat  = ovf_pos || ovf_neg;
        end
    endgenerate

    // Pops in the done cycle are ignored so the decision never depends on m_ready.
    assign fits  = (NW'(DEPTH) - count) >= NW'(K);
    assign entry = {word_sat, (idx == IW'(K-1)), word_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            idx      <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            idx      <= idx_next;
            drop     <= drop_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        idx_next      = idx;
        drop_next     = 1'b0;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (done_in) begin
                    if (fits) begin
                        idx_next = '0;
                        if (OFFSET == 1) begin
                            state_next = CAPTURE;
                        end else begin
                            wait_cnt_next = CW'(OFFSET - 1);
                            state_next    = WAIT;
                        end
                    end else begin
                        drop_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                wait_cnt_next = wait_cnt - 1'b1;
                if (wait_cnt == CW'(1)) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                push     = 1'b1;
                idx_next = idx + 1'b1;
                if (idx == IW'(K-1)) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mvm_drain_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (entry),
        .pop   (m_valid && m_ready),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

    assign m_valid = !empty;
    assign m_sat   = empty ? 1'b0 : head[EW-1];
    assign m_last  = empty ? 1'b0 : head[EW-2];
    assign m_data  = empty ? '0 : head[OUT_W-1:0];
    assign busy    = (state != IDLE);

endmodule
